zoom_coef_table: RTL
====================

Name: zoom_coef_table

Overview:
- Coefficient source that serves the zoom scaler's read side.
- Holds a per-bin signed Q16.16 gain table of FFT_POINT entries and answers the scaler's o_ram_zoom_addr with the matching coefficient on i_zoom_data, one cycle later.
- Ping-pong buffered: a new table streams into the shadow bank while the active bank is being read. Banks swap only at a frame boundary, so one frame never mixes two tables.

Parameters:
- FFT_POINT, 8192: table depth, one entry per FFT bin.
- ADDR_WIDTH, 14: address width. Must satisfy 2^ADDR_WIDTH >= FFT_POINT.
- ZOOM_MODE, 4: i_mode value in which the scaler consumes the table.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-low reset.
- i_mode  in  8  system mode, same bus the scaler sees.
- i_coef_data  in  32  signed Q16.16 coefficient to load.
- i_coef_valid  in  1  load word valid.
- i_coef_last  in  1  last word of the table being loaded.
- o_coef_ready  out  1  load side can accept a word.
- i_ram_zoom_addr  in  ADDR_WIDTH  read address from the scaler.
- i_frame_valid  in  1  rotate-stream valid, as seen by the scaler.
- i_frame_last  in  1  rotate-stream last, as seen by the scaler.
- o_zoom_data  out  32  signed Q16.16 coefficient to the scaler.
- o_active_bank  out  1  bank currently being read.
- o_swap_pending  out  1  shadow bank is full and waiting to swap.
- o_load_cnt  out  ADDR_WIDTH+1  number of words written in the last completed load.
- o_overflow  out  1  sticky: at least one load word was dropped.

Behaviour:
- Storage
  - Two banks of FFT_POINT x 32 (block RAM).
  - Both banks are initialised at configuration to 32'h0001_0000 (unity gain).
  - RAM contents are not affected by rst.
- Read path
  - o_zoom_data <= bank[o_active_bank][i_ram_zoom_addr] on every clk edge, unconditionally. Latency is exactly 1 cycle.
  - An address >= FFT_POINT returns 32'h0001_0000.
- Load FSM states: IDLE, LOAD, PEND.
  - IDLE: o_coef_ready=1. An accepted word (valid&&ready) writes shadow[0], sets wr_ptr=1 and goes to LOAD. If i_coef_last is also high, go straight to PEND.
  - LOAD: o_coef_ready=1. Each accepted word writes shadow[wr_ptr] and increments wr_ptr. An accepted word with i_coef_last goes to PEND and latches o_load_cnt = wr_ptr+1.
  - PEND: o_coef_ready=0 and o_swap_pending=1. Leave PEND through a swap (see below), then return to IDLE.
- Short load: a load shorter than FFT_POINT leaves the unwritten shadow entries with their previous contents.
- Overflow: accepted words with wr_ptr == FFT_POINT are not written. o_overflow is set sticky. The FSM stays in LOAD until last arrives, and o_load_cnt saturates at FFT_POINT.
- Swap rule
  - In PEND, swap at the first clk edge where i_frame_valid && i_frame_last, or where i_mode != ZOOM_MODE.
  - On swap, o_active_bank toggles, o_swap_pending clears and the FSM goes to IDLE.
  - The read issued in the same cycle as the swap edge still uses the old bank. The first read of the next frame uses the new bank.
- Simultaneous events
  - An accepted last word coincides with frame last: no swap in that cycle; enter PEND only. The swap happens at the next qualifying edge.
  - In IDLE or LOAD, frame last is ignored.
- o_load_cnt and o_overflow are cleared only by rst.
- Reset (rst=0, asynchronous)
  - FSM returns to IDLE; wr_ptr=0, o_active_bank=0, o_swap_pending=0, o_load_cnt=0, o_overflow=0, o_zoom_data=0, o_coef_ready=0 while reset is asserted.
  - After rst is released, o_coef_ready=1 from the first edge.
  - A reset during LOAD abandons the partial load. Shadow contents already written remain in the RAM.

Test Plan:
- Default table: after reset, i_mode=4 and addresses 0..8191 driven one per cycle -> o_zoom_data = 32'h0001_0000 for every address, each 1 cycle after its address; o_active_bank=0.
- Full load and swap: stream 8192 words with value = index, last on word 8191 while frame traffic runs -> o_swap_pending=1, o_load_cnt=8192. At the next i_frame_valid&&i_frame_last, o_active_bank=1, and the next frame reads addr 100 -> 100. Reads before that edge still return 32'h0001_0000.
- Mode-idle swap: load 4 words {2,3,4,5} with i_mode=0 -> swap on the edge after PEND is entered. addr 0..3 -> 2,3,4,5; addr 4 -> 32'h0001_0000; o_load_cnt=4.
- Backpressure: in PEND, drive i_coef_valid=1 for 50 cycles -> o_coef_ready=0 and shadow contents unchanged. After the swap, o_coef_ready=1 and the next load targets the other bank.
- Overflow: 8200 words, last on word 8199 -> o_overflow=1, o_load_cnt=8192, entry 8191 holds word 8191's value.
- Reset mid-load: assert rst after 10 words -> o_coef_ready=0 and o_active_bank=0 immediately. After release, o_active_bank=0, a 4-word load starts at shadow[0], and o_overflow=0.

Source files
------------

// File: rtl/zoom_coef_table_if.sv
`default_nettype none
// ============================================================================
//  Module   : zoom_coef_table_if
//  Brief    : Coefficient load stream and scaler read bus for zoom_coef_table.
//  Revision : 1.0 - initial release
// ============================================================================
interface zoom_coef_table_if #(
  parameter int ADDR_WIDTH = 14
);
  // Coefficient load stream
  logic [31:0]           i_coef_data;
  logic                  i_coef_valid;
  logic                  i_coef_last;
  logic                  o_coef_ready;
  // Scaler read side
  logic [ADDR_WIDTH-1:0] i_ram_zoom_addr;
  logic                  i_frame_valid;
  logic                  i_frame_last;
  logic [31:0]           o_zoom_data;

  // Loader / scaler side
  modport master (
    output i_coef_data, i_coef_valid, i_coef_last,
    output i_ram_zoom_addr, i_frame_valid, i_frame_last,
    input  o_coef_ready, o_zoom_data
  );

  // Coefficient table side
  modport slave (
    input  i_coef_data, i_coef_valid, i_coef_last,
    input  i_ram_zoom_addr, i_frame_valid, i_frame_last,
    output o_coef_ready, o_zoom_data
  );
endinterface
`default_nettype wire

// File: rtl/zoom_coef_table.sv
`default_nettype none
// ============================================================================
//  Module   : zoom_coef_table
//  Brief    : Ping-pong buffered Q16.16 per-bin gain table for the zoom scaler.
//             A new table loads into the shadow bank; banks swap only at a
//             frame boundary (or when the scaler is not in zoom mode).
//  Revision : 1.0 - initial release
// ============================================================================
module zoom_coef_table #(
  parameter int FFT_POINT  = 8192,
  parameter int ADDR_WIDTH = 14,
  parameter int ZOOM_MODE  = 4
) (
  input  wire logic              clk,
  input  wire logic              rst,          // asynchronous, active-low
  input  wire logic [7:0]        i_mode,
  zoom_coef_table_if.slave       bus,
  output logic                   o_active_bank,
  output logic                   o_swap_pending,
  output logic [ADDR_WIDTH:0]    o_load_cnt,
  output logic                   o_overflow
);

  localparam int                  IDX_W = $clog2(FFT_POINT);
  localparam logic [31:0]         UNITY = 32'h0001_0000;
  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH + 1)'(FFT_POINT);
  localparam logic [7:0]          ZMODE = 8'(ZOOM_MODE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PEND = 2'd2
  } state_t;

  // Both banks power up at unity gain; rst never touches the contents.
  logic [31:0] mem0_q [FFT_POINT] = '{default: UNITY};
  logic [31:0] mem1_q [FFT_POINT] = '{default: UNITY};

  state_t              state_q, state_d;
  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0] load_cnt_q, load_cnt_d;
  logic                overflow_q, overflow_d;
  logic                active_q, active_d;
  logic                rdy_en_q;             // low while in reset, high from first edge after
  logic [31:0]         zoom_data_q;

  logic                ready;
  logic                accept;
  logic                swap;
  logic                wr_en;
  logic [IDX_W-1:0]    wr_addr;
  logic                rd_in_range;
  logic [IDX_W-1:0]    rd_idx;
  logic [31:0]         rd_word;

  assign ready  = rdy_en_q && (state_q != S_PEND);
  assign accept = bus.i_coef_valid && ready;
  assign swap   = (bus.i_frame_valid && bus.i_frame_last) || (i_mode != ZMODE);

  // Load FSM next-state, write control, load count and overflow tracking
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    load_cnt_d = load_cnt_q;
    overflow_d = overflow_q;
    active_d   = active_q;
    wr_en      = 1'b0;
    wr_addr    = wr_ptr_q[IDX_W-1:0];
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          wr_en    = 1'b1;
          wr_addr  = '0;
          wr_ptr_d = (ADDR_WIDTH + 1)'(1);
          if (bus.i_coef_last) begin
            state_d    = S_PEND;
            load_cnt_d = (ADDR_WIDTH + 1)'(1);
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (accept) begin
          // Words past the table end are dropped and flagged, pointer saturates
          if (wr_ptr_q < DEPTH) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
          end else begin
            overflow_d = 1'b1;
          end
          if (bus.i_coef_last) begin
            state_d    = S_PEND;
            load_cnt_d = (wr_ptr_q < DEPTH) ? wr_ptr_q + 1'b1 : DEPTH;
          end
        end
      end
      S_PEND: begin
        if (swap) begin
          active_d = ~active_q;
          state_d  = S_IDLE;
          wr_ptr_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      load_cnt_q <= '0;
      overflow_q <= 1'b0;
      active_q   <= 1'b0;
      rdy_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      load_cnt_q <= load_cnt_d;
      overflow_q <= overflow_d;
      active_q   <= active_d;
      rdy_en_q   <= 1'b1;
    end
  end

  // Shadow bank write: the bank not currently being read
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (active_q) mem0_q[wr_addr] <= bus.i_coef_data;
      else          mem1_q[wr_addr] <= bus.i_coef_data;
    end
  end

  assign rd_in_range = ({1'b0, bus.i_ram_zoom_addr} < DEPTH);
  assign rd_idx      = bus.i_ram_zoom_addr[IDX_W-1:0];
  assign rd_word     = !rd_in_range ? UNITY : (active_q ? mem1_q[rd_idx] : mem0_q[rd_idx]);

  // One-cycle read from the active bank; the swap edge still reads the old bank
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) zoom_data_q <= '0;
    else      zoom_data_q <= rd_word;
  end

  assign bus.o_coef_ready = ready;
  assign bus.o_zoom_data  = zoom_data_q;
  assign o_active_bank    = active_q;
  assign o_swap_pending   = (state_q == S_PEND);
  assign o_load_cnt       = load_cnt_q;
  assign o_overflow       = overflow_q;

endmodule
`default_nettype wire
